// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS control path: opcode encoding, pc_ctrl states
// and the default program-counter width.
package picomips_pkg;

  localparam int PSIZE_DEFAULT = 6;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_MULI = 3'b011,
    OP_BEQ  = 3'b100,
    OP_BNE  = 3'b101,
    OP_JMP  = 3'b110,
    OP_WAIT = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_MUL          = 2'd1,
    ST_WAIT_PRESS   = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bundle between the instruction/ALU side and the next-address controller.
interface pc_ctrl_if
  import picomips_pkg::*;
#(
  parameter int Psize = PSIZE_DEFAULT
);
  // No handshake: every field is meaningful every cycle, and the controller's
  // outputs are a same-cycle combinational response to the inputs presented.
  logic [2:0]       opcode;
  logic [Psize-1:0] imm;
  logic             zflag;
  logic [Psize-1:0] PCout;
  logic             PCincr;
  logic [Psize-1:0] Branchaddr;
  logic             reg_we;
  logic             mul_start;
  logic             stall;

  modport master (
    output opcode, imm, zflag, PCout,
    input  PCincr, Branchaddr, reg_we, mul_start, stall
  );

  modport slave (
    input  opcode, imm, zflag, PCout,
    output PCincr, Branchaddr, reg_we, mul_start, stall
  );
endinterface

// File: rtl/pc_ctrl_btn_sync.sv
// Two-flop synchroniser for the asynchronous push-button input.
module btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;
endmodule

// File: rtl/pc_ctrl.sv
// Next-address controller for the picoMIPS program counter.
// Build option PICO_WAIT_EN adds the button-wait instruction (opcode 111).
module pc_ctrl
  import picomips_pkg::*;
#(
  parameter int Psize  = PSIZE_DEFAULT,
  parameter int MulLat = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      btn,
  pc_ctrl_if.slave  bus,
  output pc_state_t state
);
  localparam int CW = $clog2(MulLat);

  op_t              op;
  logic [CW-1:0]    cnt;
  logic             pc_incr;
  logic [Psize-1:0] baddr;
  logic             we;
  logic             mstart;
  logic             stl;

  assign op = op_t'(bus.opcode);

`ifdef PICO_WAIT_EN
  logic btn_s;
  btn_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (btn_s)
  );
`else
  logic unused_btn;
  assign unused_btn = btn;
`endif

  // Holding the PC means loading the counter with its own value.
  always_comb begin
    pc_incr = 1'b0;
    baddr   = '0;
    we      = 1'b0;
    mstart  = 1'b0;
    stl     = 1'b0;
    if (reset) begin
      case (state)
        ST_RUN: begin
          case (op)
            OP_ADD, OP_ADDI: begin
              pc_incr = 1'b1;
              we      = 1'b1;
            end
            OP_BEQ: begin
              if (bus.zflag) baddr   = bus.PCout + bus.imm;
              else           pc_incr = 1'b1;
            end
            OP_BNE: begin
              if (!bus.zflag) baddr   = bus.PCout + bus.imm;
              else            pc_incr = 1'b1;
            end
            OP_JMP: baddr = bus.imm;
            OP_MULI: begin
              baddr  = bus.PCout;
              mstart = 1'b1;
              stl    = 1'b1;
            end
`ifdef PICO_WAIT_EN
            OP_WAIT: begin
              baddr = bus.PCout;
              stl   = 1'b1;
            end
`endif
            default: pc_incr = 1'b1;
          endcase
        end
        ST_MUL: begin
          if (cnt != '0) begin
            baddr = bus.PCout;
            stl   = 1'b1;
          end else begin
            pc_incr = 1'b1;
            we      = 1'b1;
          end
        end
`ifdef PICO_WAIT_EN
        ST_WAIT_PRESS: begin
          baddr = bus.PCout;
          stl   = 1'b1;
        end
        ST_WAIT_RELEASE: begin
          if (btn_s) begin
            baddr = bus.PCout;
            stl   = 1'b1;
          end else begin
            pc_incr = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (op == OP_MULI) begin
            cnt   <= CW'(MulLat - 2);
            state <= ST_MUL;
          end
`ifdef PICO_WAIT_EN
          else if (op == OP_WAIT) begin
            state <= ST_WAIT_PRESS;
          end
`endif
        end
        ST_MUL: begin
          if (cnt != '0) cnt   <= cnt - CW'(1);
          else           state <= ST_RUN;
        end
`ifdef PICO_WAIT_EN
        ST_WAIT_PRESS:   if (btn_s)  state <= ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: if (!btn_s) state <= ST_RUN;
`endif
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.PCincr     = pc_incr;
  assign bus.Branchaddr = baddr;
  assign bus.reg_we     = we;
  assign bus.mul_start  = mstart;
  assign bus.stall      = stl;
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Next-address controller for the picoMIPS core, sitting directly upstream of the program counter. Each cycle it decodes the current instruction's opcode and immediate, the ALU zero flag and the external button, then drives the counter's increment/load controls. It computes branch targets and holds the PC for multi-cycle multiplies and for the button-wait instruction. The counter always updates on every edge: it increments when PCincr=1 and loads Branchaddr when PCincr=0. Holding the PC is therefore done by loading Branchaddr=PCout.

## Interface
- Psize, 6, PC/address width (up to 64 instructions)
- MulLat, 4, total cycles occupied by MULI; legal range 2..16
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset; the top level inverts it for the counter's active-high reset
- opcode  in  3  opcode of the instruction at PCout (program memory read is combinational)
- imm  in  Psize  branch offset (two's complement) for BEQ/BNE; absolute target for JMP
- zflag  in  1  ALU zero flag for the current instruction
- PCout  in  Psize  current counter value
- btn  in  1  raw asynchronous push-button
- PCincr  out  1  1 = counter increments; 0 = counter loads Branchaddr
- Branchaddr  out  Psize  load value for the counter
- reg_we  out  1  register-file write enable
- mul_start  out  1  one-cycle start pulse to the multiplier
- stall  out  1  1 in every cycle in which the PC is held

## Operation
- Opcodes:
  - 000 NOP
  - 001 ADD
  - 010 ADDI
  - 011 MULI
  - 100 BEQ
  - 101 BNE
  - 110 JMP
  - 111 WAIT
- FSM states: RUN, MUL, WAIT_PRESS, WAIT_RELEASE. The reset state is RUN.
- RUN, NOP: PCincr=1, reg_we=0.
- RUN, ADD/ADDI: PCincr=1, reg_we=1.
- RUN, BEQ: if zflag=1 then PCincr=0 and Branchaddr=PCout+imm; otherwise PCincr=1. No write.
- RUN, BNE: same as BEQ with the zflag condition inverted.
- RUN, JMP: PCincr=0, Branchaddr=imm.
- RUN, MULI: PCincr=0, Branchaddr=PCout, mul_start=1, stall=1. Load cnt=MulLat-2 and go to MUL.
- MUL, cnt>0: hold the PC, stall=1, decrement cnt.
- MUL, cnt=0: PCincr=1, reg_we=1, stall=0, go to RUN. MULI therefore occupies exactly MulLat cycles.
- RUN, WAIT: hold the PC, stall=1, go to WAIT_PRESS.
- WAIT_PRESS: hold until btn_s=1, then go to WAIT_RELEASE (still holding).
- WAIT_RELEASE: hold while btn_s=1. When btn_s=0, output PCincr=1 and go to RUN.
- btn_s is btn after a two-flop synchroniser.
- Relative branch arithmetic:
  - imm is sign-extended to Psize and added modulo 2^Psize; no overflow detection.
  - Wrap-around at either end is legal.
- cnt width is clog2(MulLat).
- A self-branch (imm=0) is legal and simply loops.
- Any opcode seen while the FSM is not in RUN is ignored.

## Timing
- All outputs are combinational from state, opcode, imm, zflag, PCout and cnt. The counter reflects the decision on the next rising edge: zero-cycle decision, one-cycle latency.
- While reset=0:
  - all outputs forced to 0: PCincr=0, Branchaddr=0, reg_we=0, mul_start=0, stall=0;
  - on the edge, state←RUN, cnt←0, synchroniser flops←0.
- Reset asserted mid-MUL or mid-WAIT aborts with no reg_we. Execution restarts at address 0.
- mul_start is high for exactly one cycle per MULI, and never in the same cycle as reg_we.
- Button latency: a press is seen 2 edges after btn rises (synchroniser depth). A press shorter than one clock may be missed; no debouncing is required.
- A button already held when WAIT is reached still requires a release to proceed.

## Configuration
- PICO_WAIT_EN defined:
  - WAIT behaves as above;
  - the synchroniser and the WAIT_PRESS/WAIT_RELEASE states are present.
- PICO_WAIT_EN undefined:
  - opcode 111 decodes as NOP (PCincr=1);
  - btn is unused, and the synchroniser and WAIT states are not built.

## Structure
- picomips_pkg holds:
  - the opcode typedef enum (3-bit) and its constants;
  - the pc_ctrl state typedef enum;
  - the default Psize.
- One sub-module, btn_sync: two-flop synchroniser with synchronous active-low reset. It is instantiated only under PICO_WAIT_EN.

## Test plan
- Reset: hold reset=0 for 2 cycles while opcode=MULI -> all outputs 0 and mul_start never pulses. After release, opcode=NOP -> PCincr=1.
- Branches, with Psize=6:
  - BEQ, zflag=1, PCout=62, imm=5 -> PCincr=0, Branchaddr=3;
  - BNE, zflag=0, PCout=0, imm=-1 -> Branchaddr=63;
  - BEQ, zflag=0 -> PCincr=1.
- JMP, imm=17, PCout=40 -> PCincr=0, Branchaddr=17, reg_we=0.
- MULI, MulLat=4, PCout=9:
  - mul_start=1 in cycle 0 only;
  - Branchaddr=9 and stall=1 for cycles 0-2;
  - cycle 3: PCincr=1, reg_we=1;
  - PCout=10 after cycle 3.
  - Repeat with reset=0 in cycle 1 -> no reg_we, state back to RUN.
- WAIT (PICO_WAIT_EN), PCout=20:
  - btn low for 5 cycles -> PC held at 20;
  - btn high for 4 cycles, then low -> PCincr=1 exactly 2 cycles after btn falls, then PCout=21.
- WAIT without PICO_WAIT_EN -> PCincr=1 on the first cycle with btn=0 and no stall.
